// File: rtl/axi_burst_rd_pkg.sv
// Shared definitions for the DDR capture/playback AXI masters:
// AXI field constants, controller state encodings and burst sizing helper.
package axi_burst_rd_pkg;

  localparam int BYTES_PER_BEAT = 16;
  localparam int PACKET_SIZE    = 4096;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B      = 3'd4;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Beats for the next burst: the full burst length, or whatever is left of the pass.
  function automatic logic [8:0] burst_beats(input logic [27:0] remaining,
                                             input logic [8:0]  max_beats);
    if (remaining >= {19'd0, max_beats}) begin
      return max_beats;
    end
    return remaining[8:0];
  endfunction

endpackage

// File: rtl/axi_burst_rd_skid_buf.sv
// Two-entry fully registered skid buffer between the AXI R channel and the
// AXI-Stream output. The head entry drives the output directly, so a beat
// accepted on the input is visible one cycle later, and a simultaneous
// push/pop at occupancy one keeps full throughput.
module axis_skid_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty
);

  logic [1:0]       count;
  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign empty     = (count == 2'd0);
  assign out_data  = entry0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy and storage update; entry0 is always the oldest beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            entry0 <= in_data;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            entry0 <= in_data;
          end else if (push) begin
            entry1 <= in_data;
            count  <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            entry0 <= entry1;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_rd.sv
// AXI4 read master for waveform playback: reads a captured DDR buffer back in
// INCR bursts and streams it out as AXI-Stream, optionally looping forever.
module axi_burst_rd
  import axi_burst_rd_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int BURST_BEATS     = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_rstb,
  output logic [31:0]             axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic [3:0]              axi_arcache,
  output logic [2:0]              axi_arprot,
  output logic [3:0]              axi_arid,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic [DATA_WIDTH-1:0]   axis_tdata,
  output logic [DATA_WIDTH/8-1:0] axis_tkeep,
  output logic                    axis_tlast,
  output logic                    axis_tvalid,
  input  logic                    axis_tready,
  input  logic                    read_start,
  input  logic                    read_reset,
  input  logic                    play_loop,
  input  logic [31:0]             start_address,
  input  logic [31:0]             cap_size,
  output logic                    busy,
  output logic                    rd_done,
  output logic                    rd_err,
  output logic [31:0]             current_addr,
  output logic [7:0]              run_cycles
);

  localparam int               OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
  localparam logic [8:0]       BURST_MAX = 9'(BURST_BEATS);

  logic [1:0]            state;
  logic [31:0]           base_addr;
  logic [31:0]           next_addr;
  logic [27:0]           total_beats;
  logic [27:0]           remaining;
  logic [27:0]           beat_cnt;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      outstanding_nxt;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  r_last_hs;
  logic                  axis_hs;
  logic [8:0]            issue_beats;
  logic [8:0]            cur_beats;
  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic                  skid_out_ready;
  logic                  skid_empty;
  logic [DATA_WIDTH-1:0] skid_out_data;
  logic                  unused_bits;

  assign axi_arsize  = AXI_SIZE_16B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arcache = AXI_CACHE_DEFAULT;
  assign axi_arprot  = 3'd0;
  assign axi_arid    = 4'd0;
  assign axis_tkeep  = '1;

  // Alignment bits of the base address and size never take part in the transfer.
  assign unused_bits = ^{start_address[11:0], cap_size[3:0]};

  assign ar_hs     = axi_arvalid & axi_arready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign r_last_hs = r_hs & axi_rlast;
  assign axis_hs   = axis_tvalid & axis_tready;

  assign issue_beats = burst_beats(remaining, BURST_MAX);
  assign cur_beats   = {1'b0, axi_arlen} + 9'd1;

  // In FLUSH every returning beat is swallowed; otherwise R is throttled by the buffer.
  assign axi_rready    = (state == ST_FLUSH) | skid_in_ready;
  assign skid_in_valid = axi_rvalid & (state != ST_FLUSH);

  // An abort hides the buffered beat immediately so nothing leaks downstream.
  assign axis_tvalid    = skid_out_valid & ~read_reset;
  assign skid_out_ready = axis_tready & ~read_reset;
  assign axis_tdata     = skid_out_data;
  assign axis_tlast     = axis_tvalid & (beat_cnt == (total_beats - 28'd1));

  assign busy = (state != ST_IDLE);

  // Bursts in flight: an AR handshake adds one, a returned rlast retires one.
  always_comb begin
    outstanding_nxt = outstanding;
    if (ar_hs && !r_last_hs) begin
      outstanding_nxt = outstanding + OUT_ONE;
    end else if (!ar_hs && r_last_hs) begin
      outstanding_nxt = outstanding - OUT_ONE;
    end
  end

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (axi_aclk),
    .rst_n    (axi_rstb),
    .clear    (read_reset),
    .in_data  (axi_rdata),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .out_data (skid_out_data),
    .out_valid(skid_out_valid),
    .out_ready(skid_out_ready),
    .empty    (skid_empty)
  );

  // Controller: burst issue, pass wrap-around, status flags and abort handling.
  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      state        <= ST_IDLE;
      base_addr    <= '0;
      next_addr    <= '0;
      total_beats  <= '0;
      remaining    <= '0;
      beat_cnt     <= '0;
      outstanding  <= '0;
      axi_araddr   <= '0;
      axi_arlen    <= '0;
      axi_arvalid  <= 1'b0;
      rd_done      <= 1'b0;
      rd_err       <= 1'b0;
      current_addr <= '0;
      run_cycles   <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (read_reset) begin
        axi_arvalid  <= axi_arvalid & ~axi_arready;
        rd_done      <= 1'b0;
        rd_err       <= 1'b0;
        run_cycles   <= '0;
        current_addr <= '0;
        beat_cnt     <= '0;
        if ((outstanding_nxt != '0) || (axi_arvalid && !axi_arready)) begin
          state <= ST_FLUSH;
        end else begin
          state <= ST_IDLE;
        end
      end else begin
        if (ar_hs) begin
          axi_arvalid <= 1'b0;
        end
        if (r_hs && (axi_rresp != 2'b00) && (state != ST_FLUSH)) begin
          rd_err <= 1'b1;
        end
        if (axis_hs) begin
          if (axis_tlast) begin
            beat_cnt   <= '0;
            run_cycles <= run_cycles + 8'd1;
          end else begin
            beat_cnt <= beat_cnt + 28'd1;
          end
        end
        case (state)
          ST_IDLE: begin
            if (read_start) begin
              base_addr   <= {start_address[31:12], 12'h000};
              total_beats <= cap_size[31:4];
              if (cap_size[31:4] == 28'd0) begin
                rd_done <= 1'b1;
              end else begin
                rd_done   <= 1'b0;
                rd_err    <= 1'b0;
                next_addr <= {start_address[31:12], 12'h000};
                remaining <= cap_size[31:4];
                beat_cnt  <= '0;
                state     <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            if (!axi_arvalid && (outstanding < OUT_MAX)) begin
              axi_arvalid <= 1'b1;
              axi_araddr  <= next_addr;
              axi_arlen   <= 8'(issue_beats - 9'd1);
            end
            if (ar_hs) begin
              current_addr <= axi_araddr;
              next_addr    <= next_addr + 32'({cur_beats, 4'h0});
              remaining    <= remaining - 28'(cur_beats);
              if (remaining == 28'(cur_beats)) begin
                if (play_loop) begin
                  next_addr <= base_addr;
                  remaining <= total_beats;
                end else begin
                  state <= ST_DRAIN;
                end
              end
            end
          end
          ST_DRAIN: begin
            if ((outstanding == '0) && skid_empty) begin
              rd_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          ST_FLUSH: begin
            if (!axi_arvalid && (outstanding_nxt == '0)) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_rd.sv
// Self-checking bench for axi_burst_rd: a randomised AXI read slave backed by
// an address-derived memory pattern, and a reference of the expected AR
// sequence and output stream computed from pass offsets.
module tb_axi_burst_rd;

  logic         axi_aclk = 1'b0;
  logic         axi_rstb = 1'b0;
  logic [31:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic [2:0]   axi_arsize;
  logic [1:0]   axi_arburst;
  logic [3:0]   axi_arcache;
  logic [2:0]   axi_arprot;
  logic [3:0]   axi_arid;
  logic         axi_arvalid;
  logic         axi_arready = 1'b0;
  logic [127:0] axi_rdata = '0;
  logic [1:0]   axi_rresp = 2'b00;
  logic         axi_rlast = 1'b0;
  logic         axi_rvalid = 1'b0;
  logic         axi_rready;
  logic [127:0] axis_tdata;
  logic [15:0]  axis_tkeep;
  logic         axis_tlast;
  logic         axis_tvalid;
  logic         axis_tready = 1'b0;
  logic         read_start = 1'b0;
  logic         read_reset = 1'b0;
  logic         play_loop = 1'b0;
  logic [31:0]  start_address = '0;
  logic [31:0]  cap_size = '0;
  logic         busy;
  logic         rd_done;
  logic         rd_err;
  logic [31:0]  current_addr;
  logic [7:0]   run_cycles;

  always #5 axi_aclk = ~axi_aclk;

  axi_burst_rd dut (
    .axi_aclk     (axi_aclk),
    .axi_rstb     (axi_rstb),
    .axi_araddr   (axi_araddr),
    .axi_arlen    (axi_arlen),
    .axi_arsize   (axi_arsize),
    .axi_arburst  (axi_arburst),
    .axi_arcache  (axi_arcache),
    .axi_arprot   (axi_arprot),
    .axi_arid     (axi_arid),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rlast    (axi_rlast),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axis_tdata   (axis_tdata),
    .axis_tkeep   (axis_tkeep),
    .axis_tlast   (axis_tlast),
    .axis_tvalid  (axis_tvalid),
    .axis_tready  (axis_tready),
    .read_start   (read_start),
    .read_reset   (read_reset),
    .play_loop    (play_loop),
    .start_address(start_address),
    .cap_size     (cap_size),
    .busy         (busy),
    .rd_done      (rd_done),
    .rd_err       (rd_err),
    .current_addr (current_addr),
    .run_cycles   (run_cycles)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state for the current transfer.
  logic [31:0] exp_base   = '0;
  int          exp_total  = 0;
  int          ar_off     = 0;
  int          s_off      = 0;
  int          passes     = 0;
  int          ar_count   = 0;
  int          beat_count = 0;
  int          err_beat   = -1;
  int          r_beat_idx = 0;
  bit          bp_mode    = 1'b0;
  bit          expect_stream = 1'b1;
  int          slave_out  = 0;
  int          max_out    = 0;
  int          cyc        = 0;
  int          exp_runs   = 0;
  logic [31:0] salt       = 32'h1357_9BDF;

  // Slave bookkeeping.
  logic [31:0] q_addr[$];
  int          q_beats[$];
  int          burst_pos  = 0;
  bit          r_hold     = 1'b0;
  bit          ar_waiting = 1'b0;
  logic [31:0] last_araddr = '0;
  logic [7:0]  last_arlen  = '0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory content is a pure function of the byte address and a per-test salt.
  function automatic logic [127:0] mem_word(input logic [31:0] a);
    return {a ^ salt, ~a, a + salt, a[15:0], salt[15:0]};
  endfunction

  // AXI slave plus monitors: drive on the falling edge, then judge the
  // handshakes that the next rising edge will complete.
  always begin
    @(negedge axi_aclk);
    cyc++;
    axi_arready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    axis_tready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    if (!r_hold) begin
      if ((q_addr.size() > 0) && (!bp_mode || ($urandom_range(0, 3) != 0))) begin
        axi_rvalid = 1'b1;
        axi_rdata  = mem_word(q_addr[0] + 32'(burst_pos * 16));
        axi_rlast  = (burst_pos == q_beats[0] - 1);
        axi_rresp  = (r_beat_idx == err_beat) ? 2'b10 : 2'b00;
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
      end
    end
    #1;
    if (ar_waiting) begin
      checkOutput("arvalid_held", axi_arvalid, 1);
      checkOutput("araddr_stable", axi_araddr, last_araddr);
      checkOutput("arlen_stable", axi_arlen, last_arlen);
    end
    ar_waiting  = axi_arvalid && !axi_arready;
    last_araddr = axi_araddr;
    last_arlen  = axi_arlen;
    if (axi_arvalid && axi_arready) begin
      if (exp_total > 0) begin
        int beats;
        beats = ((exp_total - ar_off) > 256) ? 256 : (exp_total - ar_off);
        checkOutput("araddr", axi_araddr, exp_base + 32'(ar_off * 16));
        checkOutput("arlen", axi_arlen, beats - 1);
        ar_off = ar_off + beats;
        if (ar_off >= exp_total) ar_off = 0;
      end
      q_addr.push_back(axi_araddr);
      q_beats.push_back(int'(axi_arlen) + 1);
      ar_count++;
      slave_out++;
      if (slave_out > max_out) max_out = slave_out;
    end
    if (axi_rvalid && axi_rready) begin
      r_hold = 1'b0;
      r_beat_idx++;
      if (axi_rlast) begin
        void'(q_addr.pop_front());
        void'(q_beats.pop_front());
        burst_pos = 0;
        slave_out--;
      end else begin
        burst_pos++;
      end
    end else begin
      r_hold = axi_rvalid;
    end
    if (axis_tvalid && axis_tready) begin
      if (!expect_stream) begin
        checkOutput("axis_tvalid_after_reset", axis_tvalid, 0);
      end else begin
        checkOutput("axis_tdata", axis_tdata, mem_word(exp_base + 32'(s_off * 16)));
        checkOutput("axis_tlast", axis_tlast, (s_off == exp_total - 1));
        beat_count++;
        s_off++;
        if (s_off == exp_total) begin
          s_off = 0;
          passes++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] size,
                               input bit loop, input bit bp, input int errb);
    @(negedge axi_aclk);
    salt          = $urandom;
    exp_base      = {addr[31:12], 12'h000};
    exp_total     = int'(size[31:4]);
    ar_off        = 0;
    s_off         = 0;
    passes        = 0;
    ar_count      = 0;
    beat_count    = 0;
    err_beat      = errb;
    r_beat_idx    = 0;
    bp_mode       = bp;
    expect_stream = 1'b1;
    max_out       = 0;
    start_address = addr;
    cap_size      = size;
    play_loop     = loop;
    read_start    = 1'b1;
    @(negedge axi_aclk);
    read_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!rd_done && n < budget) begin
      @(negedge axi_aclk);
      n++;
    end
    checkOutput("rd_done", rd_done, 1);
  endtask

  task automatic checkPass(input int exp_ars, input logic [31:0] last_ar);
    exp_runs++;
    checkOutput("ar_count", ar_count, exp_ars);
    checkOutput("beat_count", beat_count, exp_total);
    checkOutput("run_cycles", run_cycles, exp_runs);
    checkOutput("current_addr", current_addr, last_ar);
    checkOutput("busy_idle", busy, 0);
    checkOutput("max_outstanding_le4", (max_out <= 4), 1);
  endtask

  initial begin
    logic [31:0] addr;
    int nb;
    int n;

    repeat (3) @(negedge axi_aclk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_done", rd_done, 0);
    checkOutput("reset_rd_err", rd_err, 0);
    checkOutput("reset_arvalid", axi_arvalid, 0);
    checkOutput("reset_tvalid", axis_tvalid, 0);
    checkOutput("reset_run_cycles", run_cycles, 0);
    checkOutput("reset_current_addr", current_addr, 0);
    checkOutput("reset_arsize", axi_arsize, 3'd4);
    checkOutput("reset_arburst", axi_arburst, 2'b01);
    checkOutput("reset_arcache", axi_arcache, 4'b0011);
    checkOutput("reset_tkeep", axis_tkeep, 16'hFFFF);
    axi_rstb = 1'b1;
    repeat (2) @(negedge axi_aclk);

    // Single pass of two full bursts.
    addr = $urandom;
    applyStimulus(addr, 32'd8192 | 32'($urandom_range(0, 15)), 1'b0, 1'b0, -1);
    waitDone(3000);
    checkPass(2, {addr[31:12], 12'h000} + 32'h1000);
    checkOutput("rd_err_clean", rd_err, 0);

    // Full burst followed by a 64-beat tail.
    addr = $urandom;
    applyStimulus(addr, 32'd5120, 1'b0, 1'b0, -1);
    waitDone(3000);
    checkPass(2, {addr[31:12], 12'h000} + 32'h1000);

    // Stream backpressure with gaps on the R channel.
    addr = $urandom;
    nb   = $urandom_range(600, 1000);
    applyStimulus(addr, 32'(nb * 16), 1'b0, 1'b1, -1);
    waitDone(20000);
    checkPass((nb + 255) / 256, {addr[31:12], 12'h000} + 32'(((nb - 1) / 256) * 4096));
    bp_mode = 1'b0;

    // Error response on beat 10 is flagged but the data still flows.
    addr = $urandom;
    applyStimulus(addr, 32'd1024, 1'b0, 1'b0, 10);
    waitDone(2000);
    checkPass(1, {addr[31:12], 12'h000});
    checkOutput("rd_err_set", rd_err, 1);
    repeat (5) @(negedge axi_aclk);
    checkOutput("rd_err_sticky", rd_err, 1);

    // Idle abort clears the status.
    read_reset = 1'b1;
    @(negedge axi_aclk);
    read_reset = 1'b0;
    checkOutput("idle_reset_run_cycles", run_cycles, 0);
    checkOutput("idle_reset_rd_err", rd_err, 0);
    checkOutput("idle_reset_rd_done", rd_done, 0);
    checkOutput("idle_reset_busy", busy, 0);

    // Loop playback for three passes, then abort mid-stream.
    addr = $urandom;
    applyStimulus(addr, 32'd4096, 1'b1, 1'b0, -1);
    n = 0;
    while (passes < 3 && n < 5000) begin
      @(negedge axi_aclk);
      n++;
    end
    checkOutput("loop_passes", passes, 3);
    checkOutput("loop_run_cycles", run_cycles, 3);
    checkOutput("loop_ar_count_ge3", (ar_count >= 3), 1);
    read_reset    = 1'b1;
    expect_stream = 1'b0;
    @(negedge axi_aclk);
    read_reset = 1'b0;
    play_loop  = 1'b0;
    checkOutput("abort_run_cycles", run_cycles, 0);
    checkOutput("abort_current_addr", current_addr, 0);
    checkOutput("abort_rd_done", rd_done, 0);
    n = 0;
    while (busy && n < 3000) begin
      @(negedge axi_aclk);
      n++;
    end
    checkOutput("busy_after_flush", busy, 0);
    checkOutput("slave_outstanding_after_flush", slave_out, 0);
    checkOutput("arvalid_after_flush", axi_arvalid, 0);
    checkOutput("loop_max_outstanding_le4", (max_out <= 4), 1);

    // Empty capture: done on the next cycle, no AR issued.
    addr = $urandom;
    applyStimulus(addr, 32'h0000_000F, 1'b0, 1'b0, -1);
    checkOutput("empty_rd_done", rd_done, 1);
    checkOutput("empty_busy", busy, 0);
    repeat (10) @(negedge axi_aclk);
    checkOutput("empty_ar_count", ar_count, 0);
    checkOutput("empty_arvalid", axi_arvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
